// File: rtl/vga_rect_engine.sv
// vga_rect_engine: rasterises a filled or outlined axis-aligned rectangle
// into the VGA pixel-plot interface (VGA_X, VGA_Y, VGA_COLOR, plot).
// It emits at most one pixel per clock, behind a start/busy/done handshake.
//
// Optional build macro VGA_RECT_ENGINE_STALL_EN adds a plot_ready input.
// When that macro is defined, a pixel is consumed only when plot and
// plot_ready are both high. Without it, every DRAW cycle consumes a pixel.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; the command is captured on start=1
// SETUP | normalise and clip corners, load cursor or skip to DONE
// DRAW  | walk the cursor in raster order, one pixel per consumed cycle
// DONE  | one-cycle done pulse, then back to IDLE

module vga_rect_engine #(
    parameter int COLS = 160,
    parameter int ROWS = 120,
    parameter int XW   = 10,
    parameter int YW   = 9,
    parameter int CW   = 3
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] color,
    input  logic          outline,
`ifdef VGA_RECT_ENGINE_STALL_EN
    input  logic          plot_ready,
`endif
    output logic [XW-1:0] VGA_X,
    output logic [YW-1:0] VGA_Y,
    output logic [CW-1:0] VGA_COLOR,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_DRAW,
        S_DONE
    } state_t;

    // One bit wider than the coordinates, so COLS/ROWS compare without overflow.
    localparam logic [XW:0]   COLS_EXT = (XW+1)'(COLS);
    localparam logic [YW:0]   ROWS_EXT = (YW+1)'(ROWS);
    localparam logic [XW-1:0] X_MAX    = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(ROWS - 1);

    state_t state;
    state_t state_nxt;

    logic ready;

`ifdef VGA_RECT_ENGINE_STALL_EN
    assign ready = plot_ready;
`else
    assign ready = 1'b1;
`endif

    // Captured command
    logic [XW-1:0] cmd_x0;
    logic [XW-1:0] cmd_x1;
    logic [YW-1:0] cmd_y0;
    logic [YW-1:0] cmd_y1;
    logic [CW-1:0] cmd_color;
    logic          cmd_outline;

    // Normalised, clipped bounds and the raster cursor
    logic [XW-1:0] xa_r;
    logic [XW-1:0] xb_r;
    logic [YW-1:0] ya_r;
    logic [YW-1:0] yb_r;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          all_issued;

    // SETUP arithmetic
    logic [XW-1:0] norm_xa;
    logic [XW-1:0] norm_xb_raw;
    logic [XW-1:0] norm_xb;
    logic [YW-1:0] norm_ya;
    logic [YW-1:0] norm_yb_raw;
    logic [YW-1:0] norm_yb;
    logic          off_screen;

    // Cursor stepping
    logic          row_end;
    logic          last_row;
    logic          edge_row;
    logic          last_pixel;
    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;

    // Output register handshake
    logic          out_free;
    logic          load;
    logic          finish;

    // Order the corners, clip the far edges, and flag rectangles that lie entirely off-screen.
    always_comb begin
        norm_xa     = (cmd_x0 <= cmd_x1) ? cmd_x0 : cmd_x1;
        norm_xb_raw = (cmd_x0 <= cmd_x1) ? cmd_x1 : cmd_x0;
        norm_ya     = (cmd_y0 <= cmd_y1) ? cmd_y0 : cmd_y1;
        norm_yb_raw = (cmd_y0 <= cmd_y1) ? cmd_y1 : cmd_y0;
        norm_xb     = ({1'b0, norm_xb_raw} >= COLS_EXT) ? X_MAX : norm_xb_raw;
        norm_yb     = ({1'b0, norm_yb_raw} >= ROWS_EXT) ? Y_MAX : norm_yb_raw;
        off_screen  = ({1'b0, norm_xa} >= COLS_EXT) || ({1'b0, norm_ya} >= ROWS_EXT);
    end

    // Next cursor position. All tests run before any increment, so the cursor never wraps.
    // On interior outline rows the cursor jumps from xa straight to xb.
    always_comb begin
        row_end    = (cur_x == xb_r);
        last_row   = (cur_y == yb_r);
        edge_row   = (cur_y == ya_r) || last_row;
        last_pixel = row_end && last_row;
        next_x     = cur_x;
        next_y     = cur_y;
        if (row_end) begin
            next_x = xa_r;
            if (!last_row) begin
                next_y = cur_y + 1'b1;
            end
        end else if (cmd_outline && !edge_row) begin
            next_x = xb_r;
        end else begin
            next_x = cur_x + 1'b1;
        end
    end

    // The output register accepts a new pixel when it is empty or its pixel is being consumed.
    always_comb begin
        out_free = !plot || ready;
        load     = (state == S_DRAW) && !all_issued && out_free;
        finish   = (state == S_DRAW) && all_issued && out_free;
    end

    // Select the next state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SETUP;
            S_SETUP: state_nxt = off_screen ? S_DONE : S_DRAW;
            S_DRAW:  if (finish) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Hold the FSM state.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the command when start is seen in IDLE. start is ignored in all other states.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cmd_x0      <= '0;
            cmd_x1      <= '0;
            cmd_y0      <= '0;
            cmd_y1      <= '0;
            cmd_color   <= '0;
            cmd_outline <= 1'b0;
        end else if (state == S_IDLE && start) begin
            cmd_x0      <= x0;
            cmd_x1      <= x1;
            cmd_y0      <= y0;
            cmd_y1      <= y1;
            cmd_color   <= color;
            cmd_outline <= outline;
        end
    end

    // Latch the bounds in SETUP, then advance the cursor each time a pixel is loaded.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            xa_r       <= '0;
            xb_r       <= '0;
            ya_r       <= '0;
            yb_r       <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            all_issued <= 1'b0;
        end else begin
            case (state)
                S_SETUP: begin
                    xa_r       <= norm_xa;
                    xb_r       <= norm_xb;
                    ya_r       <= norm_ya;
                    yb_r       <= norm_yb;
                    cur_x      <= norm_xa;
                    cur_y      <= norm_ya;
                    all_issued <= 1'b0;
                end
                S_DRAW: begin
                    if (load) begin
                        if (last_pixel) begin
                            all_issued <= 1'b1;
                        end else begin
                            cur_x <= next_x;
                            cur_y <= next_y;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs. Coordinates hold their last value outside DRAW,
    // and a stalled pixel stays on the bus.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            VGA_X     <= '0;
            VGA_Y     <= '0;
            VGA_COLOR <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            done <= (state_nxt == S_DONE);
            if (load) begin
                VGA_X     <= cur_x;
                VGA_Y     <= cur_y;
                VGA_COLOR <= cmd_color;
                plot      <= 1'b1;
            end else if (out_free) begin
                plot <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_rect_engine.sv
// Testbench for vga_rect_engine. It builds the expected pixel list from
// the rectangle geometry (nested loops over rows and columns) and checks
// every plotted pixel against that list.
module tb_vga_rect_engine;

    localparam int COLS = 160;
    localparam int ROWS = 120;
    localparam int XW   = 10;
    localparam int YW   = 9;
    localparam int CW   = 3;
    localparam int BUDGET = 3000;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          start;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
    logic [CW-1:0] color;
    logic          outline;
    logic          ready;
    logic [XW-1:0] VGA_X;
    logic [YW-1:0] VGA_Y;
    logic [CW-1:0] VGA_COLOR;
    logic          plot;
    logic          busy;
    logic          done;

    vga_rect_engine #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .CW(CW)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .color     (color),
        .outline   (outline),
`ifdef VGA_RECT_ENGINE_STALL_EN
        .plot_ready(ready),
`endif
        .VGA_X     (VGA_X),
        .VGA_Y     (VGA_Y),
        .VGA_COLOR (VGA_COLOR),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int compared = 0;
    int mismatched = 0;
    int exp_x[$];
    int exp_y[$];
    int exp_col = 0;
    int plots_seen = 0;
    int done_pulses = 0;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: the list of pixels a rectangle must produce, in raster order.
    task automatic build(input int ax0, input int ay0, input int ax1, input int ay1, input bit outl);
        int xa, xb, ya, yb;
        xa = (ax0 < ax1) ? ax0 : ax1;
        xb = (ax0 < ax1) ? ax1 : ax0;
        ya = (ay0 < ay1) ? ay0 : ay1;
        yb = (ay0 < ay1) ? ay1 : ay0;
        if (xb > COLS - 1) xb = COLS - 1;
        if (yb > ROWS - 1) yb = ROWS - 1;
        exp_x.delete();
        exp_y.delete();
        if (xa < COLS && ya < ROWS) begin
            for (int y = ya; y <= yb; y++) begin
                for (int x = xa; x <= xb; x++) begin
                    if (!outl || y == ya || y == yb || x == xa || x == xb) begin
                        exp_x.push_back(x);
                        exp_y.push_back(y);
                    end
                end
            end
        end
    endtask

    // Every cycle with plot high must show the head of the expected list.
    // The head is consumed on cycles where ready is also high.
    always @(negedge CLOCK_50) begin
        if (!reset) begin
            if (plot) begin
                if (exp_x.size() == 0) begin
                    check("unexpected_plot", 1, 0);
                end else begin
                    check("pix_x", int'(VGA_X), exp_x[0]);
                    check("pix_y", int'(VGA_Y), exp_y[0]);
                    check("pix_color", int'(VGA_COLOR), exp_col);
                    if (ready) begin
                        void'(exp_x.pop_front());
                        void'(exp_y.pop_front());
                        plots_seen++;
                    end
                end
            end
            if (done) done_pulses++;
        end
    end

    // mode: 0 plain, 1 start re-pulsed during DRAW, 2 fixed stall at pixel 2, 3 random stall
    task automatic run_rect(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int col, input bit outl, input int mode,
                            output int first_k, output int done_k, output int n_plots,
                            output int max_run);
        int base;
        int run;
        int px, py;
        bit pp;
        build(ax0, ay0, ax1, ay1, outl);
        exp_col = col;
        base = plots_seen;
        @(posedge CLOCK_50); #1;
        x0 = XW'(ax0); y0 = YW'(ay0); x1 = XW'(ax1); y1 = YW'(ay1);
        color = CW'(col); outline = outl; start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        ready = 1'b1;
        first_k = -1; done_k = -1; max_run = 0; run = 0;
        pp = 1'b0; px = -1; py = -1;
        for (int k = 1; k <= BUDGET && done_k < 0; k++) begin
            @(posedge CLOCK_50); #1;
            if (mode == 2) ready = !(k >= 3 && k <= 5);
            else if (mode == 3) ready = ($urandom % 4) != 0;
            else ready = 1'b1;
            if (mode == 1 && k == 3) begin
                start = 1'b1; x0 = '0; y0 = '0; x1 = XW'(7); y1 = YW'(7);
                color = ~CW'(col); outline = ~outl;
            end
            if (mode == 1 && k == 4) start = 1'b0;
            @(negedge CLOCK_50);
            if (plot) begin
                if (first_k < 0) first_k = k;
                if (pp && px == int'(VGA_X) && py == int'(VGA_Y)) run++;
                else run = 1;
                if (run > max_run) max_run = run;
            end
            pp = plot; px = int'(VGA_X); py = int'(VGA_Y);
            if (done) begin
                done_k = k;
                check("plot_low_at_done", int'(plot), 0);
                check("busy_at_done", int'(busy), 1);
            end
        end
        if (done_k < 0) check("done_timeout", 0, 1);
        check("queue_drained", exp_x.size(), 0);
        @(posedge CLOCK_50); #1;
        ready = 1'b1;
        @(negedge CLOCK_50);
        check("busy_after_done", int'(busy), 0);
        check("done_one_cycle", int'(done), 0);
        n_plots = plots_seen - base;
    endtask

    initial begin
        int fk, dk, np, mr, base_done;
        int rx0, ry0, rx1, ry1;
        reset = 1'b1; start = 1'b0; ready = 1'b1; outline = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_x", int'(VGA_X), 0);
        check("rst_y", int'(VGA_Y), 0);
        check("rst_color", int'(VGA_COLOR), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;

        // Model pins for the test-plan rectangles
        build(3, 4, 4, 5, 1'b0);
        check("model_fill_count", exp_x.size(), 4);
        check("model_fill_first_x", exp_x[0], 3);
        check("model_fill_last_y", exp_y[3], 5);
        build(10, 20, 13, 22, 1'b1);
        check("model_outline_count", exp_x.size(), 10);
        check("model_outline_5th_x", exp_x[4], 10);
        check("model_outline_6th_x", exp_x[5], 13);
        exp_x.delete(); exp_y.delete();

        // Fill (3,4)-(4,5): first plot after edge t+2, done after t+6
        run_rect(3, 4, 4, 5, 5, 1'b0, 0, fk, dk, np, mr);
        check("fill_first_plot_edge", fk, 2);
        check("fill_done_edge", dk, 6);
        check("fill_count", np, 4);
        check("fill_no_repeat", mr, 1);

        run_rect(10, 20, 13, 22, 2, 1'b1, 0, fk, dk, np, mr);
        check("outline_count", np, 10);

        run_rect(4, 5, 3, 4, 5, 1'b0, 0, fk, dk, np, mr);
        check("swapped_count", np, 4);
        check("swapped_done_edge", dk, 6);

        run_rect(158, 119, 170, 119, 7, 1'b0, 0, fk, dk, np, mr);
        check("clip_count", np, 2);

        run_rect(200, 10, 200, 12, 1, 1'b0, 0, fk, dk, np, mr);
        check("offscreen_count", np, 0);
        check("offscreen_done_early", int'(dk <= 2), 1);

        run_rect(5, 5, 5, 9, 3, 1'b1, 0, fk, dk, np, mr);
        check("width1_outline_count", np, 5);
        run_rect(20, 30, 26, 30, 4, 1'b1, 0, fk, dk, np, mr);
        check("height1_outline_count", np, 7);

        run_rect(50, 60, 52, 62, 6, 1'b0, 1, fk, dk, np, mr);
        check("start_ignored_count", np, 9);

        // Reset while the 3rd pixel of a 4x4 fill is on the bus
        build(0, 0, 3, 3, 1'b0);
        exp_col = 2;
        base_done = done_pulses;
        @(posedge CLOCK_50); #1;
        x0 = '0; y0 = '0; x1 = XW'(3); y1 = YW'(3); color = CW'(2); outline = 1'b0; start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        repeat (4) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_mid_third_plot", int'(plot), 1);
        check("rst_mid_third_x", int'(VGA_X), 2);
        reset = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_mid_plot", int'(plot), 0);
        check("rst_mid_busy", int'(busy), 0);
        reset = 1'b0;
        exp_x.delete(); exp_y.delete();
        repeat (8) @(negedge CLOCK_50);
        check("rst_mid_no_done", done_pulses - base_done, 0);
        check("rst_mid_idle_busy", int'(busy), 0);

`ifdef VGA_RECT_ENGINE_STALL_EN
        run_rect(3, 4, 4, 5, 5, 1'b0, 2, fk, dk, np, mr);
        check("stall_hold_cycles", mr, 4);
        check("stall_count", np, 4);
`endif

        // Random rectangles, filled and outlined, some partly or fully off-screen
        for (int i = 0; i < 16; i++) begin
            rx0 = $urandom_range(0, 199);
            ry0 = $urandom_range(0, 139);
            rx1 = rx0 + $urandom_range(0, 12) - 6;
            ry1 = ry0 + $urandom_range(0, 8) - 4;
            if (rx1 < 0) rx1 = 0;
            if (ry1 < 0) ry1 = 0;
            build(rx0, ry0, rx1, ry1, 1'(i % 2));
            begin
                int want;
                want = exp_x.size();
`ifdef VGA_RECT_ENGINE_STALL_EN
                run_rect(rx0, ry0, rx1, ry1, i % 8, 1'(i % 2), 3, fk, dk, np, mr);
`else
                run_rect(rx0, ry0, rx1, ry1, i % 8, 1'(i % 2), 0, fk, dk, np, mr);
`endif
                check("rand_count", np, want);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_rect_engine.md
Name: vga_rect_engine

Overview:
Parametrised VGA drawing engine that rasterises an axis-aligned rectangle, filled or outline, into the pixel-plot interface (X, Y, colour, plot strobe) used by the simulator's VGA display. It generalises the fixed-width pixel port to configurable resolution and colour depth. It accepts a start/busy/done command handshake and emits at most one pixel per clock. It sits between demo control logic and the top-level VGA_X/VGA_Y/VGA_COLOR/plot outputs.

Parameters:
COLS, 160, visible columns; x >= COLS is off-screen
ROWS, 120, visible rows; y >= ROWS is off-screen
XW, 10, X coordinate width (2^XW >= COLS)
YW, 9, Y coordinate width (2^YW >= ROWS)
CW, 3, colour width

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-high reset
start  in  1  command strobe, sampled only in IDLE
x0  in  XW  corner A column
y0  in  YW  corner A row
x1  in  XW  corner B column
y1  in  YW  corner B row
color  in  CW  rectangle colour
outline  in  1  0 = filled, 1 = border only
VGA_X  out  XW  pixel column
VGA_Y  out  YW  pixel row
VGA_COLOR  out  CW  pixel colour
plot  out  1  pixel valid strobe
busy  out  1  high from SETUP through DONE
done  out  1  one-cycle completion pulse

Behaviour:
- One clock (CLOCK_50). Reset is synchronous and active-high.
- Reset: state IDLE; VGA_X=0, VGA_Y=0, VGA_COLOR=0, plot=0, busy=0, done=0. Reset asserted mid-draw: next edge returns to IDLE with plot=0; no further pixels.
- All outputs are registered.
- States: IDLE -> SETUP -> DRAW -> DONE -> IDLE.
- IDLE: on start=1, register x0,y0,x1,y1,color,outline; go to SETUP. start is ignored in every other state.
- SETUP: normalise xa=min(x0,x1), xb=max(x0,x1), ya=min(y0,y1), yb=max(y0,y1). Clip xb to COLS-1 and yb to ROWS-1. If xa>=COLS or ya>=ROWS, go to DONE with zero plots. Otherwise load cursor (xa,ya) and go to DRAW.
- DRAW: each cycle drives VGA_X/VGA_Y/VGA_COLOR = cursor/colour with plot=1.
- Raster order: x increments first; at x=xb, x wraps to xa and y increments.
- Leave DRAW after plotting (xb,yb); go to DONE.
- Outline mode: on rows ya and yb, every x is plotted. On interior rows, xa is plotted and the next x is xb (jump), so the interior is never emitted. A width-1 rectangle plots one pixel per row. A height-1 rectangle plots one row.
- Outline pixel count = 2W+2H-4 for W,H >= 2. Fill pixel count = W*H.
- Latency: start sampled at edge t. First plot=1 is visible after edge t+2. The last pixel is visible for one cycle, then done=1 for exactly one cycle with plot=0. busy falls together with done.
- Outside DRAW, plot=0. VGA_X/Y/COLOR hold their last values.
- Coordinate arithmetic is unsigned at widths XW/YW. Comparisons are done before any increment, so the cursor never wraps past 2^XW-1.

Optional Feature:
Macro VGA_RECT_ENGINE_STALL_EN.
- Defined: adds input port plot_ready (1 bit, after outline).
- In DRAW, a pixel is consumed only on a cycle where plot=1 and plot_ready=1.
- While plot_ready=0, VGA_X/Y/COLOR and plot=1 hold stable and the cursor does not advance.
- Entering DONE requires the last pixel to be consumed.
- Reset overrides a stall.
- Not defined: no plot_ready port; every DRAW cycle consumes one pixel.

Test Plan:
- Fill (3,4)-(4,5), color=5, start at edge t -> plots (3,4),(4,4),(3,5),(4,5) on edges t+2..t+5, colour 5; done=1 only after edge t+6; then busy=0.
- Outline x0=10,y0=20,x1=13,y1=22 -> 10 plots: (10..13,20),(10,21),(13,21),(10..13,22) in that order; no (11,21) or (12,21).
- Swapped corners x0=4,y0=5,x1=3,y1=4, fill -> identical pixel sequence to scenario 1.
- Clipping x0=158,x1=170,y0=119,y1=119 -> plots (158,119),(159,119) only. Separately, x0=x1=200 -> zero plots, done after 2 cycles.
- Start pulsed during DRAW with different coordinates -> ignored, original rectangle completes. Reset at 3rd pixel of a 4x4 fill -> plot=0 the next cycle, busy=0, no done pulse.
- With VGA_RECT_ENGINE_STALL_EN defined, hold plot_ready=0 for 3 cycles at the 2nd pixel -> (VGA_X,VGA_Y) stable for 4 cycles; total pixel count unchanged at 4.
